// File: rtl/controller_pkg.sv
// Shared definitions for the controller packet receiver: FSM states, sync marker,
// button bit positions and the UART bit-level state encodings.
package controller_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } rx_state_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   localparam int BTN_JUMP  = 0;
   localparam int BTN_DASH  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_UP    = 4;
   localparam int BTN_DOWN  = 5;
   localparam int BTN_Y     = 6;

   localparam logic [1:0] UART_IDLE  = 2'd0;
   localparam logic [1:0] UART_START = 2'd1;
   localparam logic [1:0] UART_DATA  = 2'd2;
   localparam logic [1:0] UART_STOP  = 2'd3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid strobe, bytes with a
// broken stop bit are dropped so they never reach the packet FSM.
module uart_rx
   import controller_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

   logic             rx_meta;
   logic             rx_sync;
   logic [1:0]       state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // blocking here would turn the two-stage synchroniser into one wire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= UART_IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         data    <= '0;
         valid   <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            UART_IDLE: begin
               clk_cnt <= '0;
               if (!rx_sync) state <= UART_START;
            end
            UART_START: begin
               // Re-check the start bit at its centre to reject line glitches.
               if (clk_cnt == HALF_CNT) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_sync ? UART_IDLE : UART_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            UART_DATA: begin
               if (clk_cnt == FULL_CNT) begin
                  clk_cnt <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  if (bit_idx == 3'd7) state <= UART_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            UART_STOP: begin
               if (clk_cnt == FULL_CNT) begin
                  clk_cnt <= '0;
                  state   <= UART_IDLE;
                  if (rx_sync) begin
                     data  <= shift;
                     valid <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: state <= UART_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/controller_packet_rx.sv
// Framed, checksummed button-packet receiver: publishes a registered button
// vector with press/release strobes and a watchdog-derived link status.
module controller_packet_rx
   import controller_pkg::*;
#(
   parameter int         CLKS_PER_BIT   = 868,
   parameter int         NUM_BYTES      = 2,
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         GAP_CYCLES     = 200_000,
   parameter int         TIMEOUT_CYCLES = 10_000_000,
   localparam int        NB             = 8 * NUM_BYTES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          uart_rx_in,
   output logic [NB-1:0] buttons,
   output logic [NB-1:0] pressed,
   output logic [NB-1:0] released,
   output logic          connected,
   output logic          frame_ok,
   output logic          frame_err,
   output logic [7:0]    err_count
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IDX_W = $clog2(NUM_BYTES + 1);

   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_EXPIRED = WD_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BYTES - 1);

   logic [7:0]       rx_data;
   logic             rx_valid;
   rx_state_e        state;
   logic [IDX_W-1:0] idx;
   logic [7:0]       xor_acc;
   logic [NB-1:0]    shadow;
   logic [GAP_W-1:0] gap_cnt;
   logic [WD_W-1:0]  wd_cnt;

   logic check_byte;
   logic good_frame;
   logic bad_frame;
   logic wd_expire;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_rx (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (uart_rx_in),
      .data (rx_data),
      .valid(rx_valid)
   );

   assign check_byte = rx_valid && (state == ST_CHECK);
   assign good_frame = check_byte && (rx_data == xor_acc);
   assign bad_frame  = check_byte && (rx_data != xor_acc);
   // A good frame in the expiry cycle wins, so expiry is suppressed by it.
   assign wd_expire  = !good_frame && (wd_cnt == WD_LAST);

   // NOTE: the shadow register is reset with the rest of the datapath; it is a
   // handful of flops, not a RAM, and a deterministic value keeps sims clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_HUNT;
         idx     <= '0;
         xor_acc <= '0;
         shadow  <= '0;
         gap_cnt <= '0;
      end else if (rx_valid) begin
         gap_cnt <= '0;
         case (state)
            ST_HUNT: begin
               if (rx_data == SYNC_BYTE) begin
                  idx     <= '0;
                  xor_acc <= '0;
                  state   <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               for (int b = 0; b < NUM_BYTES; b++) begin
                  if (idx == IDX_W'(b)) shadow[b*8 +: 8] <= rx_data;
               end
               xor_acc <= xor_acc ^ rx_data;
               idx     <= idx + 1'b1;
               if (idx == IDX_LAST) state <= ST_CHECK;
            end
            ST_CHECK: state <= ST_HUNT;
            default:  state <= ST_HUNT;
         endcase
      end else if (state != ST_HUNT) begin
         // Inter-byte silence abandons the partial frame without flagging an error.
         if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_HUNT;
         end else begin
            gap_cnt <= gap_cnt + 1'b1;
         end
      end else begin
         gap_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buttons   <= '0;
         pressed   <= '0;
         released  <= '0;
         connected <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_count <= '0;
         wd_cnt    <= '0;
      end else begin
         pressed   <= '0;
         released  <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;

         if (good_frame) wd_cnt <= '0;
         else if (wd_cnt != WD_EXPIRED) wd_cnt <= wd_cnt + 1'b1;

         if (good_frame) begin
            buttons   <= shadow;
            pressed   <= shadow & ~buttons;
            released  <= buttons & ~shadow;
            connected <= 1'b1;
            frame_ok  <= 1'b1;
         end else if (wd_expire) begin
            buttons   <= '0;
            released  <= buttons;
            connected <= 1'b0;
         end

         if (bad_frame) begin
            frame_err <= 1'b1;
            err_count <= sat_inc8(err_count);
         end
      end
   end

endmodule
